uart_tx_buf: RTL
================

# uart_tx_buf

Transmit-side byte buffer and launch controller placed directly upstream of the UART transmitter. It accepts bytes from the APB register side into a synchronous FIFO and hands them to the transmitter one at a time. For each byte it pulses `tx_start` with `tx_din` stable, then waits for `tx_done_tick` before launching the next byte. The block provides back-to-back serial frames without CPU polling of the transmitter's busy flag.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `AW`, `$clog2(DEPTH)`: pointer width; derived, not overridden.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `wr_en`  in  1  write request from the APB side; one byte per cycle.
- `wr_data`  in  8  byte to enqueue.
- `full`  out  1  high when `count == DEPTH`.
- `empty`  out  1  high when `count == 0`.
- `count`  out  AW+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  one-cycle pulse when a write is dropped.
- `tx_start`  out  1  one-cycle launch pulse to the transmitter.
- `tx_din`  out  8  byte for the transmitter; stable from the `tx_start` cycle until the next pop.
- `tx_busy`  in  1  transmitter is not idle.
- `tx_done_tick`  in  1  transmitter finished its stop bit.

## Operation
- Write path:
  - `wr_en && !full` stores `wr_data` at `wr_ptr`, increments `wr_ptr` (wraps mod DEPTH), and increments `count`.
  - `wr_en && full` drops the byte, pulses `overflow` for 1 cycle, and leaves the FIFO unchanged.
  - `full` is evaluated on the pre-edge count. A write to a full FIFO is dropped even if a pop happens in the same cycle.
- Pop: pops happen only in state BUF_IDLE. A pop loads `mem[rd_ptr]` into the `tx_din` register and increments `rd_ptr`, wrapping mod DEPTH.
- Simultaneous write and pop: `count` is unchanged and both pointers advance.
- FSM, with states in this order: BUF_IDLE, BUF_START, BUF_SEND.
  - BUF_IDLE: if `!empty && !tx_busy`, pop and go to BUF_START; otherwise stay.
  - BUF_START: `tx_start = 1`; unconditionally go to BUF_SEND.
  - BUF_SEND: wait; on `tx_done_tick` go to BUF_IDLE.
- `tx_start` is decoded as `state == BUF_START`. Because it comes straight from the state register, it is glitch-free and exactly 1 cycle wide.
- `tx_done_tick` is ignored in BUF_IDLE and BUF_START.
- A `tx_busy` high in BUF_IDLE, for example a transmitter started by another master, holds off the pop.
- Reset (`rst_n == 0` at an edge) overrides everything:
  - State goes to BUF_IDLE and the pointers and `count` go to 0.
  - `tx_din` goes to 8'h00, and `tx_start` and `overflow` go to 0.
  - FIFO contents are not cleared, but they are unreachable after reset.
  - A reset mid-frame abandons the frame. The transmitter's own reset must accompany it at the system level.

## Timing
- Reset values: `full` 0, `empty` 1, `count` 0, `overflow` 0, `tx_start` 0, `tx_din` 8'h00.
- Write into an empty buffer with an idle transmitter:
  - `wr_en` sampled at edge E.
  - `count` = 1 after E.
  - Pop and BUF_START at E+1.
  - `tx_start` high during the cycle between E+1 and E+2.
  - The transmitter latches `tx_din` at E+2.
- Frame-to-frame gap:
  - `tx_done_tick` sampled at edge D moves the FSM to BUF_IDLE.
  - The transmitter is idle after D, so the pop happens at D+1.
  - `tx_start` is high during the D+1..D+2 cycle.
  - Result: 2 idle `clk` cycles between frames.
- `overflow` is asserted in the cycle after the offending write edge.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [1:0] {BUF_IDLE, BUF_START, BUF_SEND} buf_state_t`.
  - `localparam` for the default `DEPTH`.
- Sub-module `sync_fifo #(DW=8, DEPTH)`:
  - Holds the storage array, pointers, `count`, `full`/`empty`, and overflow detection.
  - `uart_tx_buf` instantiates it and adds the launch FSM and the `tx_din` register.

## Test plan
- Reset: hold `rst_n` low 3 cycles with `wr_en` = 1 → `empty` = 1, `count` = 0, `tx_start` = 0, no `overflow`.
- Single byte: write 8'hA5 into an idle system → `tx_start` pulses exactly once, 2 cycles after the write edge, with `tx_din` = 8'hA5; the transmitter emits start bit, 10100101 LSB-first, stop bit.
- Burst: write 8'h01, 8'h02, 8'h03 on consecutive cycles → three frames are sent in order; each `tx_start` comes 2 cycles after the previous `tx_done_tick`; `count` goes 3 → 0.
- Full/overflow with DEPTH = 4 and the transmitter held busy: write 6 bytes → `full` = 1 after the 4th; `overflow` pulses twice; bytes 5 and 6 are never transmitted.
- Wrap and simultaneous access: keep writing while draining so both pointers wrap at least twice, including a write on the pop cycle → `count` stays consistent and the byte order is preserved.
- Mid-frame reset: assert `rst_n` low while in BUF_SEND with 2 bytes queued → after release `count` = 0, the FSM is in BUF_IDLE, and no `tx_start` occurs.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-side buffer.
package uart_pkg;

  typedef enum logic [1:0] {
    BUF_IDLE,
    BUF_START,
    BUF_SEND
  } buf_state_t;

  localparam int DEFAULT_DEPTH = 16;

endpackage

// File: rtl/uart_tx_buf_sync_fifo.sv
// Synchronous byte FIFO with occupancy count and dropped-write pulse.
module sync_fifo #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // full is the pre-edge value, so a write into a full FIFO is dropped even when a pop frees a slot
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage is not cleared on reset; pointers make old contents unreachable
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Transmit byte buffer: queues bytes and launches them one at a time,
// waiting for the transmitter's done tick between frames.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        overflow,
  output logic        tx_start,
  output logic [7:0]  tx_din,
  input  logic        tx_busy,
  input  logic        tx_done_tick
);

  buf_state_t state;
  buf_state_t state_next;
  logic       pop;
  logic [7:0] rd_data;

  sync_fifo #(
    .DW    (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  // tx_start straight from the state register keeps it glitch-free and one cycle wide
  assign tx_start = (state == BUF_START);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      BUF_IDLE: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          state_next = BUF_START;
        end
      end
      BUF_START: state_next = BUF_SEND;
      BUF_SEND: begin
        if (tx_done_tick) state_next = BUF_IDLE;
      end
      default: state_next = BUF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= BUF_IDLE;
      tx_din <= 8'h00;
    end else begin
      state <= state_next;
      if (pop) tx_din <= rd_data;
    end
  end

endmodule
